// File: rtl/jam_cost_server.sv
// jam_cost_server
//   Responder side of the JAM worker/job cost interface. It holds the
//   N x N cost table and answers (W,J) lookups combinationally. The table is
//   loaded from a host stream. The assignment engine is held in reset during
//   the load and then released. The engine's MatchCount/MinCost are captured
//   on the first Valid, or a timeout is flagged if Valid never arrives.
//
//   Optional feature macro: JAM_COST_RUNSTAT_EN adds run_cycles[15:0]. It
//   reports the run-counter value at capture.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   ld_start        begin a new table load (honoured in S_IDLE / S_DONE)
//   ld_valid        load word valid
//   ld_data         cost word, row-major (entry k -> W=k/N, J=k%N)
//   ld_ready        high while loading
//   jam_rst         reset to the assignment engine
//   W, J            lookup indices from the engine
//   Cost            table[W][J], combinational, 0 outside S_RUN/S_DONE
//   Valid           engine result valid
//   MatchCount      engine match count
//   MinCost         engine minimum cost
//   res_done        result (or timeout) captured
//   res_timeout     Valid not seen within TIMEOUT run cycles
//   res_mincost     captured MinCost
//   res_match       captured MatchCount
//   run_cycles      (JAM_COST_RUNSTAT_EN only) run counter at capture
module jam_cost_server #(
  parameter int N        = 8,
  parameter int COST_W   = 7,
  parameter int HOLD_CYC = 2,
  parameter int TIMEOUT  = 4096
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [COST_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              jam_rst,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  input  logic              Valid,
  input  logic [3:0]        MatchCount,
  input  logic [9:0]        MinCost,
  output logic              res_done,
  output logic              res_timeout,
  output logic [9:0]        res_mincost,
  output logic [3:0]        res_match
`ifdef JAM_COST_RUNSTAT_EN
  ,
  output logic [15:0]       run_cycles
`endif
);

  localparam int DEPTH = N * N;
  localparam int AW    = 6;
  localparam int HW    = $clog2(HOLD_CYC + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [COST_W-1:0] r_table [DEPTH];
  logic [AW-1:0]     r_word_cnt;
  logic [HW-1:0]     r_hold_cnt;
  logic [15:0]       r_run_cnt;
  logic              r_res_done;
  logic              r_res_timeout;
  logic [9:0]        r_res_mincost;
  logic [3:0]        r_res_match;

  logic          w_start;
  logic          w_accept;
  logic          w_last_word;
  logic          w_hold_end;
  logic          w_capture;
  logic          w_timeout;
  logic          w_in_range;
  logic [AW-1:0] w_rd_addr;

  // A start pulse while already loading/holding/running is ignored. A word
  // offered in the start cycle is not accepted, because ld_ready is still 0
  // in that cycle.
  assign w_start     = ld_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_accept    = (r_state == S_LOAD) && ld_valid;
  assign w_last_word = w_accept && (r_word_cnt == AW'(DEPTH - 1));
  assign w_hold_end  = (r_state == S_HOLD) && (r_hold_cnt == HW'(HOLD_CYC));
  // Valid wins over a timeout in the same cycle.
  assign w_capture   = (r_state == S_RUN) && Valid;
  assign w_timeout   = (r_state == S_RUN) && !Valid && (r_run_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_LOAD;
      S_LOAD: if (w_last_word) w_next = S_HOLD;
      S_HOLD: if (w_hold_end) w_next = S_RUN;
      S_RUN:  if (w_capture || w_timeout) w_next = S_DONE;
      S_DONE: if (w_start) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  // The hold counter runs 0..HOLD_CYC. As a result, jam_rst drops
  // HOLD_CYC+1 edges after the edge that took the last word. The run counter
  // freezes at capture, so it reads the number of edges from the jam_rst
  // fall to the Valid edge, minus one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_word_cnt    <= '0;
      r_hold_cnt    <= '0;
      r_run_cnt     <= '0;
      r_res_done    <= 1'b0;
      r_res_timeout <= 1'b0;
      r_res_mincost <= '0;
      r_res_match   <= '0;
    end else if (w_start) begin
      r_word_cnt    <= '0;
      r_hold_cnt    <= '0;
      r_run_cnt     <= '0;
      r_res_done    <= 1'b0;
      r_res_timeout <= 1'b0;
      r_res_mincost <= '0;
      r_res_match   <= '0;
    end else begin
      case (r_state)
        S_LOAD: if (w_accept) r_word_cnt <= r_word_cnt + 1'b1;
        S_HOLD: if (!w_hold_end) r_hold_cnt <= r_hold_cnt + 1'b1;
        S_RUN: begin
          if (w_capture) begin
            r_res_mincost <= MinCost;
            r_res_match   <= MatchCount;
            r_res_done    <= 1'b1;
          end else if (w_timeout) begin
            r_res_timeout <= 1'b1;
            r_res_done    <= 1'b1;
          end else begin
            r_run_cnt <= r_run_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // The table has no reset. A reset mid-load leaves partial contents,
  // which only a full reload makes usable again.
  always_ff @(posedge CLK) begin
    if (w_accept && !RST) r_table[r_word_cnt] <= ld_data;
  end

  generate
    if (N < 8) begin : g_range
      assign w_in_range = (int'(W) < N) && (int'(J) < N);
    end else begin : g_full
      assign w_in_range = 1'b1;
    end
  endgenerate

  assign w_rd_addr = AW'(int'(W) * N + int'(J));

  always_comb begin
    Cost = '0;
    if ((r_state == S_RUN || r_state == S_DONE) && w_in_range)
      Cost = r_table[w_rd_addr];
  end

  assign ld_ready    = (r_state == S_LOAD);
  assign jam_rst     = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_HOLD);
  assign res_done    = r_res_done;
  assign res_timeout = r_res_timeout;
  assign res_mincost = r_res_mincost;
  assign res_match   = r_res_match;

`ifdef JAM_COST_RUNSTAT_EN
  assign run_cycles = r_run_cnt;
`endif

endmodule

// File: tb/tb_jam_cost_server.sv
// Testbench for jam_cost_server: random table loads, lookups, capture,
// timeout and mid-load reset, checked against a table/latency model.
module tb_jam_cost_server;
  localparam int N        = 8;
  localparam int COST_W   = 7;
  localparam int HOLD_CYC = 2;
  localparam int TIMEOUT  = 16;

  logic              CLK = 1'b0;
  logic              RST;
  logic              ld_start;
  logic              ld_valid;
  logic [COST_W-1:0] ld_data;
  logic              ld_ready;
  logic              jam_rst;
  logic [2:0]        W;
  logic [2:0]        J;
  logic [COST_W-1:0] Cost;
  logic              Valid;
  logic [3:0]        MatchCount;
  logic [9:0]        MinCost;
  logic              res_done;
  logic              res_timeout;
  logic [9:0]        res_mincost;
  logic [3:0]        res_match;
`ifdef JAM_COST_RUNSTAT_EN
  logic [15:0]       run_cycles;
`endif

  always #5 CLK = ~CLK;

  jam_cost_server #(
    .N(N), .COST_W(COST_W), .HOLD_CYC(HOLD_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RST(RST), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .jam_rst(jam_rst),
    .W(W), .J(J), .Cost(Cost), .Valid(Valid), .MatchCount(MatchCount),
    .MinCost(MinCost), .res_done(res_done), .res_timeout(res_timeout),
    .res_mincost(res_mincost), .res_match(res_match)
`ifdef JAM_COST_RUNSTAT_EN
    , .run_cycles(run_cycles)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [COST_W-1:0] m_table [N*N];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int idx(input logic [2:0] w, input logic [2:0] j);
    return int'(w) * N + int'(j);
  endfunction

  task automatic fill_random();
    for (int k = 0; k < N*N; k++) m_table[k] = COST_W'($urandom);
  endtask

  // Load m_table. The model says each offered word is taken while loading,
  // ld_ready falls after N*N takes, and jam_rst falls HOLD_CYC+1 edges later.
  task automatic load_table(input bit gaps, input bit collide);
    int acc;
    int cyc;
    int k;
    ld_start = 1'b1;
    ld_valid = collide;
    ld_data  = ~m_table[0];
    tick();
    ld_start = 1'b0;
    check_eq("ld_ready_on", ld_ready, 1);
    check_eq("clr_done", res_done, 0);
    check_eq("clr_timeout", res_timeout, 0);
    check_eq("clr_mincost", res_mincost, 0);
    check_eq("clr_match", res_match, 0);
    acc = 0;
    cyc = 0;
    while (acc < N*N && cyc < 1000) begin
      ld_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      ld_data  = m_table[acc];
      W = 3'($urandom);
      J = 3'($urandom);
      #1;
      check_eq("ld_ready_load", ld_ready, 1);
      if (acc % 16 == 0) check_eq("cost_zero_load", Cost, 0);
      tick();
      if (ld_valid) acc++;
      cyc++;
    end
    ld_valid = 1'b0;
    check_eq("load_words", acc, N*N);
    check_eq("ld_ready_off", ld_ready, 0);
    k = 0;
    while (jam_rst === 1'b1 && k < 20) begin
      check_eq("cost_zero_hold", Cost, 0);
      tick();
      k++;
    end
    check_eq("hold_len", k, HOLD_CYC + 1);
  endtask

  // Entered right after jam_rst fell. Do d lookups (one per cycle), then
  // assert Valid, so the run counter at capture equals d.
  task automatic run_valid(input int d, input bit fixed, input logic [9:0] mc, input logic [3:0] mt);
    for (int i = 0; i < d; i++) begin
      if (fixed && i == 0) begin W = 3'd3; J = 3'd5; end
      else if (fixed && i == 1) begin W = 3'd7; J = 3'd7; end
      else begin W = 3'($urandom); J = 3'($urandom); end
      ld_start = (i == 2);
      tick();
      ld_start = 1'b0;
      check_eq("cost_run", Cost, m_table[idx(W, J)]);
      if (fixed && i == 0) check_eq("cost_3_5", Cost, 29);
      if (fixed && i == 1) check_eq("cost_7_7", Cost, 63);
      if (i == 2) check_eq("start_ignored", ld_ready, 0);
      check_eq("done_early", res_done, 0);
    end
    Valid = 1'b1;
    MinCost = mc;
    MatchCount = mt;
    tick();
    Valid = 1'b0;
    check_eq("res_done", res_done, 1);
    check_eq("res_timeout0", res_timeout, 0);
    check_eq("res_mincost", res_mincost, mc);
    check_eq("res_match", res_match, mt);
    check_eq("jam_rst_done", jam_rst, 0);
`ifdef JAM_COST_RUNSTAT_EN
    check_eq("run_cycles", run_cycles, d);
`endif
    Valid = 1'b1;
    MinCost = ~mc;
    MatchCount = ~mt;
    tick();
    tick();
    Valid = 1'b0;
    check_eq("hold_mincost", res_mincost, mc);
    check_eq("hold_match", res_match, mt);
    check_eq("hold_done", res_done, 1);
    W = 3'd0;
    J = 3'd0;
    #1;
    check_eq("cost_0_0", Cost, m_table[0]);
    W = 3'($urandom);
    J = 3'($urandom);
    #1;
    check_eq("cost_done", Cost, m_table[idx(W, J)]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    RST = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    W = '0; J = '0; Valid = 1'b0; MatchCount = '0; MinCost = '0;
    tick();
    tick();
    RST = 1'b0;
    check_eq("rst_ld_ready", ld_ready, 0);
    check_eq("rst_jam_rst", jam_rst, 1);
    check_eq("rst_done", res_done, 0);
    check_eq("rst_timeout", res_timeout, 0);
    check_eq("rst_mincost", res_mincost, 0);
    check_eq("rst_match", res_match, 0);
    check_eq("rst_cost", Cost, 0);
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    check_eq("idle_valid_ignored", ld_ready, 0);

    // Pattern table w*8+j, with a word offered in the start cycle.
    for (int i = 0; i < N*N; i++) m_table[i] = COST_W'(i);
    load_table(1'b0, 1'b1);
    run_valid(12, 1'b1, 10'd323, 4'd2);

    // Timeout: never assert Valid.
    fill_random();
    load_table(1'b1, 1'b0);
    k = 0;
    while (res_done !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check_eq("timeout_len", k, TIMEOUT);
    check_eq("timeout_flag", res_timeout, 1);
    check_eq("timeout_mincost", res_mincost, 0);
    check_eq("timeout_match", res_match, 0);
`ifdef JAM_COST_RUNSTAT_EN
    check_eq("timeout_run_cycles", run_cycles, TIMEOUT - 1);
`endif

    // Valid in the same cycle as the timeout: Valid wins.
    fill_random();
    load_table(1'b1, 1'b0);
    run_valid(TIMEOUT - 1, 1'b0, 10'($urandom), 4'($urandom));

    // Reset in the middle of a load, then a full reload.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ld_valid = 1'b1;
      ld_data  = COST_W'($urandom);
      tick();
    end
    ld_valid = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_eq("midrst_ld_ready", ld_ready, 0);
    check_eq("midrst_jam_rst", jam_rst, 1);
    check_eq("midrst_cost", Cost, 0);
    check_eq("midrst_done", res_done, 0);
    tick();
    check_eq("midrst_idle", ld_ready, 0);
    fill_random();
    load_table(1'b1, 1'b0);
    run_valid($urandom_range(0, TIMEOUT - 2), 1'b0, 10'($urandom), 4'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
